// File: rtl/aca_recovery_ctrl.sv
// Almost-correct adder sequencer: windowed speculative sum with a conservative error flag,
// plus an optional chunked ripple pass that recomputes flagged results exactly.
module aca_recovery_ctrl #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 8,
  parameter int CHUNK  = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] input1_i,
  input  logic [WIDTH-1:0] input2_i,
  input  logic             accurate_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             err_o,
  output logic             exact_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NSTART = WIDTH - WINDOW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_CORRECT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               acc_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               err_q;
  logic               exact_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               rc_q;

  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   g;
  logic [WIDTH:0]     cs;
  logic [NSTART-1:0]  run;
  logic               flag;
  logic [WIDTH-1:0]   spec_sum;
  logic               spec_carry;

  logic [CHUNK-1:0]   a_ch [NCHUNK];
  logic [CHUNK-1:0]   b_ch [NCHUNK];
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   sum_upd;

  assign p = a_q ^ b_q;
  assign g = a_q & b_q;

  // Each speculative carry only looks back WINDOW-1 bits and assumes a zero carry-in there.
  assign cs[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi <= WIDTH; gi++) begin : g_spec
      localparam int LO = (gi >= WINDOW) ? gi - WINDOW + 1 : 0;
      logic c;
      always_comb begin
        c = 1'b0;
        for (int j = LO; j < gi; j++) begin
          c = g[j] | (p[j] & c);
        end
      end
      assign cs[gi] = c;
    end

    // A run of WINDOW-1 propagates starting above bit 0 may hide a carry from below the window.
    for (gi = 1; gi <= NSTART; gi++) begin : g_flag
      assign run[gi-1] = &p[gi +: WINDOW-1];
    end

    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
      assign sum_upd[gi*CHUNK +: CHUNK] = (idx_q == IDX_W'(gi)) ? chunk_sum[CHUNK-1:0]
                                                                 : sum_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign flag       = |run;
  assign spec_sum   = p ^ cs[WIDTH-1:0];
  assign spec_carry = cs[WIDTH];
  assign chunk_sum  = {1'b0, a_ch[idx_q]} + {1'b0, b_ch[idx_q]} + {{CHUNK{1'b0}}, rc_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      exact_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rc_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (valid_i && ready_q) begin
            a_q     <= input1_i;
            b_q     <= input2_i;
            acc_q   <= accurate_i;
            ready_q <= 1'b0;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          sum_q   <= spec_sum;
          carry_q <= spec_carry;
          err_q   <= flag;
          if (flag && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (flag && acc_q) begin
            exact_q <= 1'b0;
            idx_q   <= '0;
            rc_q    <= 1'b0;
            state_q <= S_CORRECT;
          end else begin
            exact_q <= ~flag;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_CORRECT: begin
          sum_q <= sum_upd;
          rc_q  <= chunk_sum[CHUNK];
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NCHUNK - 1)) begin
            carry_q <= chunk_sum[CHUNK];
            exact_q <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;
  assign err_o       = err_q;
  assign exact_o     = exact_q;
  assign err_count_o = cnt_q;

endmodule

// File: tb/tb_aca_recovery_ctrl.sv
// Bench for aca_recovery_ctrl: transaction-level reference model checked every cycle,
// directed cases with literal expectations, then randomized operations.
module tb_aca_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] input1_i = '0;
  logic [31:0] input2_i = '0;
  logic        accurate_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] sum_o;
  logic        carry_o;
  logic        err_o;
  logic        exact_o;
  logic [15:0] err_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aca_recovery_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .input1_i   (input1_i),
    .input2_i   (input2_i),
    .accurate_i (accurate_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .err_o      (err_o),
    .exact_o    (exact_o),
    .err_count_o(err_count_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the adder rules: arithmetic over each window, run search on p.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b, input logic acc,
                                   output logic [31:0] s, output logic c, output logic f,
                                   output logic x);
    logic [32:0] ex;
    logic [32:0] cs;
    logic [31:0] p;
    p  = a ^ b;
    f  = 1'b0;
    for (int st = 1; st <= 25; st++) begin
      if (((p >> st) & 32'h7F) == 32'h7F) f = 1'b1;
    end
    cs = '0;
    for (int i = 1; i <= 32; i++) begin
      int lo;
      int len;
      longint unsigned m;
      longint unsigned t;
      lo  = (i >= 8) ? i - 7 : 0;
      len = i - lo;
      m   = (64'd1 << len) - 64'd1;
      t   = ((64'(a) >> lo) & m) + ((64'(b) >> lo) & m);
      cs[i] = ((t >> len) & 64'd1) != 0;
    end
    if (!f || acc) begin
      ex = {1'b0, a} + {1'b0, b};
      s  = ex[31:0];
      c  = ex[32];
      x  = 1'b1;
    end else begin
      s = p ^ cs[31:0];
      c = cs[32];
      x = 1'b0;
    end
  endfunction

  // Transaction model: idle/ready, busy for a fixed latency, holding a result until taken.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_wait  = 0;
  logic        m_first = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_show  = 1'b1;
  logic [31:0] m_sum   = '0;
  logic        m_carry = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_exact = 1'b0;
  logic [15:0] m_cnt   = '0;
  logic [31:0] r_sum;
  logic        r_carry, r_flag, r_exact;
  logic        started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst_i) begin
      m_phase = M_IDLE; m_ready = 1'b0; m_valid = 1'b0; m_show = 1'b1;
      m_sum = '0; m_carry = 1'b0; m_err = 1'b0; m_exact = 1'b0; m_cnt = '0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (m_ready && valid_i) begin
            model_op(input1_i, input2_i, accurate_i, r_sum, r_carry, r_flag, r_exact);
            m_wait  = (r_flag && accurate_i) ? 5 : 1;
            m_first = 1'b1;
            m_ready = 1'b0;
            m_show  = 1'b0;
            m_phase = M_BUSY;
          end else begin
            m_ready = 1'b1;
          end
        end
        M_BUSY: begin
          if (m_first && r_flag && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          m_first = 1'b0;
          m_wait  = m_wait - 1;
          if (m_wait == 0) begin
            m_phase = M_DONE; m_valid = 1'b1; m_show = 1'b1;
            m_sum = r_sum; m_carry = r_carry; m_err = r_flag; m_exact = r_exact;
          end
        end
        default: begin
          if (ready_i) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
            m_phase = M_IDLE;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ready_o", 64'(ready_o), 64'(m_ready));
      check("valid_o", 64'(valid_o), 64'(m_valid));
      check("err_count_o", 64'(err_count_o), 64'(m_cnt));
      if (m_show) begin
        check("sum_o", 64'(sum_o), 64'(m_sum));
        check("carry_o", 64'(carry_o), 64'(m_carry));
        check("err_o", 64'(err_o), 64'(m_err));
        check("exact_o", 64'(exact_o), 64'(m_exact));
      end
    end
  end

  // Issues one operation, optionally pulsing valid_i while busy, then holds the result
  // for 'hold' cycles before taking it. Latency counts cycles from the handshake cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic acc,
                       input int hold, input logic noise,
                       output int lat, output logic [31:0] s, output logic c,
                       output logic e, output logic x);
    int t;
    t = 0;
    while (ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'(ready_o), 64'd1);
    input1_i = a; input2_i = b; accurate_i = acc; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 40) begin
      if (noise) begin
        valid_i  = 1'($urandom_range(0, 1));
        input1_i = $urandom; input2_i = $urandom; accurate_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("valid_timeout", 64'(valid_o), 64'd1);
    s = sum_o; c = carry_o; e = err_o; x = exact_o;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        valid_i = 1'($urandom_range(0, 1));
        input1_i = $urandom; input2_i = $urandom;
      end
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b0;
  endtask

  int          lat;
  logic [31:0] s;
  logic        c, e, x;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready_o", 64'(ready_o), 64'd0);
    check("reset_sum_o", 64'(sum_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(ready_o), 64'd1);

    // T1: no flag
    do_op(32'h12345678, 32'h11111111, 1'b1, 0, 1'b0, lat, s, c, e, x);
    check("T1_lat", 64'(lat), 64'd2);
    check("T1_sum", 64'(s), 64'h23456789);
    check("T1_cex", 64'({c, e, x}), 64'b001);

    // T2: speculative result returned
    do_op(32'h00FFFFFF, 32'h00000001, 1'b0, 0, 1'b0, lat, s, c, e, x);
    check("T2_lat", 64'(lat), 64'd2);
    check("T2_sum", 64'(s), 64'h00FFFF00);
    check("T2_ex", 64'({e, x}), 64'b10);
    check("T2_cnt", 64'(err_count_o), 64'd1);

    // T3: corrected
    do_op(32'h00FFFFFF, 32'h00000001, 1'b1, 0, 1'b0, lat, s, c, e, x);
    check("T3_lat", 64'(lat), 64'd6);
    check("T3_sum", 64'(s), 64'h01000000);
    check("T3_cex", 64'({c, e, x}), 64'b011);

    // T4: carry-out, exact then speculative
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 1'b0, lat, s, c, e, x);
    check("T4a_sum", 64'(s), 64'h0);
    check("T4a_cx", 64'({c, x}), 64'b11);
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, lat, s, c, e, x);
    check("T4b_ce", 64'({c, e}), 64'b01);
    check("T4b_cnt", 64'(err_count_o), 64'd4);

    // T5: backpressure with valid_i pulses; outputs must stay put
    do_op(32'h0000F0F0, 32'h00000F0F, 1'b0, 0, 1'b0, lat, s, c, e, x);
    for (int i = 0; i < 5; i++) begin
      input1_i = $urandom; input2_i = $urandom; valid_i = 1'b1; ready_i = 1'b0;
      // only the first loop iteration waits out the op; later ones just stall
      if (i == 0) begin
        input1_i = 32'h00FFFFFF; input2_i = 32'h00000001; accurate_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int k = 0; k < 10 && valid_o !== 1'b1; k++) @(negedge clk);
        s = sum_o; c = carry_o; e = err_o; x = exact_o;
        valid_i = 1'b1;
      end
      @(negedge clk);
      check("T5_hold_valid", 64'(valid_o), 64'd1);
      check("T5_hold_sum", 64'(sum_o), 64'(s));
    end
    check("T5_sum", 64'(s), 64'h01000000);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("T5_idle_valid", 64'(valid_o), 64'd0);
    check("T5_idle_ready", 64'(ready_o), 64'd1);

    // T6: reset during the second correction cycle
    input1_i = 32'h00FFFFFF; input2_i = 32'h00000001; accurate_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("T6_valid", 64'(valid_o), 64'd0);
    check("T6_cnt", 64'(err_count_o), 64'd0);
    check("T6_outs", 64'({sum_o, carry_o, err_o, exact_o, ready_o}), 64'd0);
    do_op(32'h12345678, 32'h11111111, 1'b1, 0, 1'b0, lat, s, c, e, x);
    check("T6_T1_sum", 64'(s), 64'h23456789);
    check("T6_T1_lat", 64'(lat), 64'd2);

    // Randomized operations; mode 1 biases toward long propagate runs
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      int mode;
      mode = $urandom_range(0, 2);
      a = $urandom;
      case (mode)
        0: b = $urandom;
        1: b = ~a ^ ($urandom & $urandom & $urandom);
        default: begin a = a & 32'h000003FF; b = $urandom & 32'h000003FF; end
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, lat, s, c, e, x);
      $display("op %0d: a=%08h b=%08h sum=%08h c=%0b err=%0b exact=%0b lat=%0d",
               n, a, b, s, c, e, x, lat);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
